// File: rtl/msgpu_bus_pkg.sv
// rtl/msgpu_bus_pkg.sv - shared types for the msgpu MCU bus receiver
package msgpu_bus_pkg;

    localparam int BUS_ENTRY_W = 9;

    typedef enum logic [2:0] {
        WAIT_LOW,
        LOW,
        RISE,
        HIGH,
        FALL
    } strobe_state_t;

    typedef struct packed {
        logic       is_command;
        logic [7:0] data;
    } bus_entry_t;

endpackage

// File: rtl/msgpu_sync_fifo.sv
// rtl/msgpu_sync_fifo.sv - single-clock first-word fall-through FIFO
module msgpu_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (level == (AW + 1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/msgpu_bus_receiver.sv
// rtl/msgpu_bus_receiver.sv - MCU parallel bus capture into a FIFO; MSGPU_BUS_OVERFLOW_COUNT_EN adds overflow_count
module msgpu_bus_receiver
    import msgpu_bus_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          mcu_bus_clock,
    input  logic [7:0]                    mcu_bus,
    input  logic                          mcu_bus_command_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          out_is_command,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clear
`ifdef MSGPU_BUS_OVERFLOW_COUNT_EN
    ,
    output logic [15:0]                   overflow_count
`endif
);
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] FILTER_MAX = CNT_W'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [SYNC_STAGES-1:0][BUS_ENTRY_W:0] sync_q;
    logic [SYNC_STAGES-1:0]                sync_fill;
    logic                                  strobe_s;
    bus_entry_t                            sample_s;

    strobe_state_t    state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    bus_entry_t       latch_q, latch_next;
    logic             push;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    bus_entry_t       head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            sync_fill <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], {mcu_bus_clock, mcu_bus_command_data, mcu_bus}};
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign strobe_s = sync_q[SYNC_STAGES-1][BUS_ENTRY_W];
    assign sample_s = bus_entry_t'(sync_q[SYNC_STAGES-1][BUS_ENTRY_W-1:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= WAIT_LOW;
            cnt     <= '0;
            latch_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            latch_q <= latch_next;
        end
    end

    // WAIT_LOW ignores the reset zeros still in the synchronizer until real pin samples arrive.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_next = latch_q;
        push       = 1'b0;
        case (state)
            WAIT_LOW: if (sync_fill[SYNC_STAGES-1] && !strobe_s) state_next = LOW;
            LOW: begin
                if (strobe_s) begin
                    state_next = RISE;
                    cnt_next   = CNT_ONE;
                    latch_next = sample_s;
                end
            end
            RISE: begin
                if (!strobe_s) begin
                    state_next = LOW;
                    latch_next = '0;
                end else if (cnt == FILTER_MAX) begin
                    state_next = HIGH;
                    push       = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!strobe_s) begin
                    state_next = FALL;
                    cnt_next   = CNT_ONE;
                end
            end
            FALL: begin
                if (strobe_s) begin
                    state_next = HIGH;
                end else if (cnt == FILTER_MAX) begin
                    state_next = LOW;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: state_next = WAIT_LOW;
        endcase
    end

    msgpu_sync_fifo #(
        .WIDTH (BUS_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (latch_q),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid      = ~fifo_empty;
    assign pop            = out_valid & out_ready;
    assign drop           = push & fifo_full & ~pop;
    assign out_data       = out_valid ? head.data : 8'h00;
    assign out_is_command = out_valid & head.is_command;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

`ifdef MSGPU_BUS_OVERFLOW_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= '0;
        end else if (drop) begin
            if (overflow_clear)
                overflow_count <= 16'd1;
            else if (overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
        end else if (overflow_clear) begin
            overflow_count <= '0;
        end
    end
`endif

endmodule
